// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per
//   clock, least-significant chunk first, and keeps the carry between chunks
//   in a register. This gives a short critical path at the cost of NCHUNK
//   cycles of latency. Only one operation is in flight at a time.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits added per cycle (1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin/sub are valid       (in)
//   in_ready   block is idle and accepts    (out)
//   a, b       operands                     (in)
//   cin        carry-in, add mode only      (in)
//   sub        0: a+b+cin, 1: a-b           (in)
//   out_valid  result is valid              (out)
//   out_ready  consumer takes the result    (in)
//   sum        result modulo 2^WIDTH        (out)
//   carry_out  carry out of MSB; in subtract mode 1 means no borrow (out)
//   overflow   two's-complement overflow    (out)
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the index at least one bit wide so CHUNK == WIDTH still elaborates.
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDXW-1:0]     idx_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;        // holds b, or ~b in subtract mode
  logic [WIDTH-1:0]    sum_q;
  logic                co_q;
  logic                ov_q;
  logic                in_ready_q;
  logic                out_valid_q;

  // Operand capture values.
  logic [WIDTH-1:0]    b_eff_d;
  logic                carry_init_d;

  // Per-chunk arithmetic.
  logic [CHUNK-1:0]    a_chunk;
  logic [CHUNK-1:0]    b_chunk;
  logic [CHUNK:0]      chunk_res_d;
  logic                last_chunk;
  logic                ov_d;

  always_comb begin
    b_eff_d      = sub ? ~b : b;
    // Subtraction is a + ~b + 1, so the injected carry replaces cin.
    carry_init_d = sub ? 1'b1 : cin;
  end

  always_comb begin
    a_chunk     = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk     = b_q[idx_q*CHUNK +: CHUNK];
    chunk_res_d = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
    last_chunk  = (idx_q == LAST_IDX);
    // On the last chunk the chunk MSB is the result sign bit; overflow when
    // both addends share a sign and the result sign differs from it.
    ov_d        = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (chunk_res_d[CHUNK-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b_eff_d;
            carry_q    <= carry_init_d;
            idx_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end
        end

        BUSY: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_res_d[CHUNK-1:0];
          carry_q                     <= chunk_res_d[CHUNK];
          if (last_chunk) begin
            idx_q       <= '0;
            co_q        <= chunk_res_d[CHUNK];
            ov_q        <= ov_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: directed vectors on the default 16/4
// configuration plus random sweeps on 16/1, 16/16 and 8/2 against a
// signed-arithmetic reference model. Expected results go into a per-instance
// queue; a monitor compares on out_valid.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          sweep_go = 1'b0;
  int          done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g == 3) ? 8 : 16;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
    localparam int N = W / C;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    // Expected {overflow, carry_out, sum}.
    logic [W+1:0] expq[$];

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
    );

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
      logic [W-1:0] be;
      logic [W:0]   full;
      longint       sa, sb, sr;
      logic         ov;
      be   = ms ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
      sa   = ma[W-1] ? longint'(ma) - (longint'(1) <<< W) : longint'(ma);
      sb   = mb[W-1] ? longint'(mb) - (longint'(1) <<< W) : longint'(mb);
      sr   = ms ? (sa - sb) : (sa + sb + longint'(mc));
      ov   = (sr > ((longint'(1) <<< (W-1)) - 1)) || (sr < -(longint'(1) <<< (W-1)));
      return {ov, full[W], full[W-1:0]};
    endfunction

    // Present one operation, hold in_valid for the accept edge, then scramble
    // the inputs so a design reading live operands would be caught.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
      int n = 0;
      while (!in_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((expq.size() != 0 || !in_ready) && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("idle_timeout", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: compares on the rising of out_valid, then checks that the
    // result holds while stalled and that the block is ready after handoff.
    initial begin
      logic         prev_v = 1'b0;
      logic         prev_hs = 1'b0;
      int unsigned  acc = 0;
      logic [W+1:0] exp_v;
      logic [W+1:0] held = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_v = 1'b0;
          prev_hs = 1'b0;
          continue;
        end
        if (prev_hs) begin
          check("valid_drop", 32'(out_valid), 32'd0);
          check("ready_after", 32'(in_ready), 32'd1);
        end
        if (out_valid) begin
          if (!prev_v) begin
            if (expq.size() == 0) begin
              check("unexpected_out", 32'd1, 32'd0);
            end else begin
              exp_v = expq.pop_front();
              check("sum", 32'(sum), 32'(exp_v[W-1:0]));
              check("carry_out", 32'(carry_out), 32'(exp_v[W]));
              check("overflow", 32'(overflow), 32'(exp_v[W+1]));
              check("latency", cyc - acc, 32'(N));
            end
            held = {overflow, carry_out, sum};
          end else begin
            check("held", 32'({overflow, carry_out, sum}), 32'(held));
            check("ready_busy", 32'(in_ready), 32'd0);
          end
        end
        if (in_valid && in_ready) acc = cyc + 1;
        prev_v  = out_valid;
        prev_hs = out_valid && out_ready;
      end
    end

    if (g == 0) begin : drv
      initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Plain add, wrap-around add, add with carry-in into overflow.
        expq.push_back({1'b0, 1'b0, 16'h0100}); issue(16'h00FF, 16'h0001, 1'b0, 1'b0); wait_idle();
        expq.push_back({1'b0, 1'b1, 16'h0000}); issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_idle();
        expq.push_back({1'b1, 1'b0, 16'h8000}); issue(16'h7FFF, 16'h0000, 1'b1, 1'b0); wait_idle();
        // Subtract: borrow case (cin ignored) and signed overflow case.
        expq.push_back({1'b0, 1'b0, 16'hFFFE}); issue(16'h0005, 16'h0007, 1'b1, 1'b1); wait_idle();
        expq.push_back({1'b1, 1'b1, 16'h7FFF}); issue(16'h8000, 16'h0001, 1'b0, 1'b1); wait_idle();

        // Backpressure with in_valid/a/b churning while the result is held.
        out_ready = 1'b0;
        expq.push_back({1'b0, 1'b0, 16'h0100}); issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          in_valid = ~in_valid; a = 16'($urandom); b = 16'($urandom);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset after two BUSY cycles: the operation must vanish.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        expq.push_back({1'b0, 1'b0, 16'h0003}); issue(16'h0001, 16'h0002, 1'b0, 1'b0); wait_idle();

        // Random sweeps on the other configurations.
        sweep_go = 1'b1;
        n = 0;
        while (done_cnt < 3 && n < 60000) begin
          @(posedge clk);
          n++;
        end
        check("sweep_done", 32'(done_cnt), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end else begin : drv
      initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        wait (sweep_go);
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
          ra = W'($urandom); rb = W'($urandom);
          rc = 1'($urandom); rs = 1'($urandom);
          expq.push_back(model(ra, rb, rc, rs));
          issue(ra, rb, rc, rs);
        end
        wait_idle();
        done_cnt++;
      end
    end
  end

endmodule
